// File: rtl/pipeline_defs.sv
// rtl/pipeline_defs.sv - shared pipeline definitions: divider state encoding and width
package pipeline_defs;

    localparam int DIV_WIDTH = 32;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_CALC = 2'd1,
        DIV_DONE = 2'd2
    } divState_t;

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring-division iteration
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] remIn,
    input  logic             dividendBit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] remOut,
    output logic             quoBit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    assign shifted = {remIn, dividendBit};
    assign diff    = shifted - {1'b0, divisor};

    // remIn < divisor keeps shifted < 2*divisor, so diff's top bit is set exactly when the trial went negative
    assign quoBit  = ~diff[WIDTH];
    assign remOut  = quoBit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/div_unit.sv
// rtl/div_unit.sv - multi-cycle radix-2 restoring divider for DIV/DIVU in EX
module div_unit
    import pipeline_defs::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               signed_div,
    input  logic               annul,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] result,
    output logic               ready,
    output logic               busy
);

    localparam int CW = $clog2(WIDTH + 1);

    divState_t        state;
    divState_t        nextState;
    logic [CW-1:0]    counter;
    logic [WIDTH-1:0] dividendReg;
    logic [WIDTH-1:0] divisorReg;
    logic [WIDTH-1:0] remReg;
    logic             signQ;
    logic             signR;

    logic [WIDTH-1:0] absA;
    logic [WIDTH-1:0] absB;
    logic [WIDTH-1:0] stepRem;
    logic             stepQ;
    logic [WIDTH-1:0] quoFinal;
    logic [WIDTH-1:0] quoFix;
    logic [WIDTH-1:0] remFix;

    assign absA = (signed_div && a[WIDTH-1]) ? (~a + 1'b1) : a;
    assign absB = (signed_div && b[WIDTH-1]) ? (~b + 1'b1) : b;

    div_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .remIn      (remReg),
        .dividendBit(dividendReg[WIDTH-1]),
        .divisor    (divisorReg),
        .remOut     (stepRem),
        .quoBit     (stepQ)
    );

    // The dividend register shifts out dividend bits and shifts in quotient bits
    assign quoFinal = {dividendReg[WIDTH-2:0], stepQ};
    assign quoFix   = signQ ? (~quoFinal + 1'b1) : quoFinal;
    assign remFix   = signR ? (~stepRem + 1'b1) : stepRem;

    assign busy = (state != DIV_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= DIV_IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            DIV_IDLE: if (start) nextState = (b == '0) ? DIV_DONE : DIV_CALC;
            DIV_CALC: if (counter == CW'(1)) nextState = DIV_DONE;
            DIV_DONE: nextState = DIV_IDLE;
            default:  nextState = DIV_IDLE;
        endcase
        if (annul) nextState = DIV_IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            counter     <= '0;
            dividendReg <= '0;
            divisorReg  <= '0;
            remReg      <= '0;
            signQ       <= 1'b0;
            signR       <= 1'b0;
            result      <= '0;
            ready       <= 1'b0;
        end else begin
            ready <= (nextState == DIV_DONE);
            case (state)
                DIV_IDLE: begin
                    if (start && !annul) begin
                        divisorReg  <= absB;
                        dividendReg <= absA;
                        remReg      <= '0;
                        counter     <= CW'(WIDTH);
                        signQ       <= signed_div & (a[WIDTH-1] ^ b[WIDTH-1]);
                        signR       <= signed_div & a[WIDTH-1];
                        // Divide by zero: skip iteration, remainder is the raw dividend
                        if (b == '0) begin
                            result <= {a, {WIDTH{1'b1}}};
                        end
                    end
                end
                DIV_CALC: begin
                    remReg      <= stepRem;
                    dividendReg <= quoFinal;
                    counter     <= counter - CW'(1);
                    if (nextState == DIV_DONE) begin
                        result <= {remFix, quoFix};
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - directed self-checking bench for div_unit
module tb_div_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic        signed_div;
    logic        annul;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] result;
    logic        ready;
    logic        busy;

    int passed = 0;
    int total  = 0;

    div_unit #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .signed_div(signed_div),
        .annul     (annul),
        .a         (a),
        .b         (b),
        .result    (result),
        .ready     (ready),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Start in cycle 0, wait (bounded) for ready, check latency and result, then drop start
    task automatic doDiv(input string tag, input logic sgn, input logic [31:0] av,
                         input logic [31:0] bv, input logic [63:0] exp, input int expLat);
        int lat;
        a = av; b = bv; signed_div = sgn; start = 1'b1;
        lat = -1;
        for (int c = 1; c <= 40 && lat < 0; c++) begin
            step(1);
            if (ready) lat = c;
        end
        chk({tag, "_lat"}, 64'(lat), 64'(expLat));
        chk({tag, "_res"}, result, exp);
        start = 1'b0;
        step(1);
        chk({tag, "_rdy_off"}, {63'd0, ready}, 64'd0);
        chk({tag, "_idle"}, {63'd0, busy}, 64'd0);
    endtask

    initial begin
        int lat1;
        int lat2;
        int pulses;
        logic [63:0] held;

        rst = 1'b1; start = 1'b0; signed_div = 1'b0; annul = 1'b0; a = '0; b = '0;
        step(2);
        chk("reset_result", result, 64'd0);
        chk("reset_ready", {63'd0, ready}, 64'd0);
        chk("reset_busy", {63'd0, busy}, 64'd0);
        rst = 1'b0;
        step(1);

        doDiv("divu_100_7", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33);
        doDiv("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33);
        doDiv("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, {32'd1, 32'hFFFF_FFFD}, 33);
        doDiv("div_m100_m7", 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, {32'hFFFF_FFFE, 32'd14}, 33);
        doDiv("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, 33);
        doDiv("divu_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1, {32'd0, 32'hFFFF_FFFF}, 33);
        doDiv("divu_big_div", 1'b0, 32'hFFFF_FFFF, 32'h8000_0000, {32'h7FFF_FFFF, 32'd1}, 33);
        doDiv("div_m7_unsigned", 1'b0, 32'hFFFF_FFF9, 32'd2, {32'd1, 32'h7FFF_FFFC}, 33);
        doDiv("div0_u", 1'b0, 32'h1234_5678, 32'd0, {32'h1234_5678, 32'hFFFF_FFFF}, 1);
        doDiv("div0_s", 1'b1, 32'hFFFF_FFF9, 32'd0, {32'hFFFF_FFF9, 32'hFFFF_FFFF}, 1);

        // Annul mid-divide: result must keep the previous value
        held = {32'hFFFF_FFF9, 32'hFFFF_FFFF};
        a = 32'd50; b = 32'd5; signed_div = 1'b0; start = 1'b1;
        step(10);
        chk("annul_busy_before", {63'd0, busy}, 64'd1);
        annul = 1'b1;
        step(1);
        annul = 1'b0; start = 1'b0;
        chk("annul_busy", {63'd0, busy}, 64'd0);
        chk("annul_ready", {63'd0, ready}, 64'd0);
        chk("annul_result", result, held);
        step(1);
        chk("annul_ready2", {63'd0, ready}, 64'd0);
        doDiv("after_annul", 1'b0, 32'd1000, 32'd3, {32'd1, 32'd333}, 33);

        // Back-to-back DIVUs with start held high, operands swapped at DONE
        a = 32'd200; b = 32'd9; signed_div = 1'b0; start = 1'b1;
        lat1 = -1;
        for (int c = 1; c <= 40 && lat1 < 0; c++) begin
            step(1);
            if (ready) lat1 = c;
        end
        chk("b2b_lat1", 64'(lat1), 64'd33);
        chk("b2b_res1", result, {32'd2, 32'd22});
        a = 32'd9; b = 32'd200;
        lat2 = -1;
        for (int c = 1; c <= 40 && lat2 < 0; c++) begin
            step(1);
            if (ready) lat2 = c;
        end
        chk("b2b_gap", 64'(lat2), 64'd34);
        chk("b2b_res2", result, {32'd9, 32'd0});
        start = 1'b0;
        step(1);
        chk("b2b_rdy_off", {63'd0, ready}, 64'd0);

        // Asynchronous reset in the middle of CALC
        a = 32'd100; b = 32'd7; start = 1'b1;
        step(5);
        chk("pre_rst_busy", {63'd0, busy}, 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst_result", result, 64'd0);
        chk("arst_ready", {63'd0, ready}, 64'd0);
        chk("arst_busy", {63'd0, busy}, 64'd0);
        start = 1'b0;
        step(2);
        rst = 1'b0;
        pulses = 0;
        for (int c = 0; c < 40; c++) begin
            step(1);
            if (ready) pulses++;
        end
        chk("arst_no_ready", 64'(pulses), 64'd0);
        chk("arst_idle", {63'd0, busy}, 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
